// File: rtl/gf_symbol_fifo_pkg.sv
// Shared constants and types for the GF(2^M) symbol buffer between RS decoder stages.
// Default geometry holds one RS(31,k) codeword plus one spare symbol.
package gf_symbol_fifo_pkg;

    localparam int GF_M = 5;
    localparam int RS_N = 31;
    localparam int RS_T = 3;

    localparam int FIFO_DEPTH_DEF = RS_N + 1;
    localparam int FIFO_AF_DEF    = 28;

    // Per-cycle handshake outcome, encoded as {pop, push}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/gf_symbol_fifo_if.sv
// Valid/ready symbol stream into and out of gf_symbol_fifo.
// master = producer/consumer side, slave = the FIFO.
interface gf_symbol_fifo_if
    import gf_symbol_fifo_pkg::*;
#(
    parameter int WIDTH = GF_M
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/gf_sym_ram.sv
// DEPTH x WIDTH symbol store: synchronous write, asynchronous read.
// Contents are never reset; the FIFO gates out_data so stale words stay invisible.
module gf_sym_ram #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 32
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/gf_symbol_fifo.sv
// Synchronous first-word-fall-through symbol FIFO with hold (stall), flush and sticky overflow.
// Priority each cycle: reset > flush > hold > normal push/pop.
module gf_symbol_fifo
    import gf_symbol_fifo_pkg::*;
#(
    parameter int WIDTH    = GF_M,
    parameter int DEPTH    = FIFO_DEPTH_DEF,
    parameter int AF_LEVEL = FIFO_AF_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   hold,
    gf_symbol_fifo_if.slave        bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   almost_full,
    output logic                   overflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  rdata;

    logic     active;
    logic     full;
    logic     empty;
    logic     push;
    logic     pop;
    fifo_op_e op;

    assign active = ~reset & ~flush & ~hold;
    assign full   = (cnt == FULL_CNT);
    assign empty  = (cnt == '0);

    assign bus.in_ready  = active & ~full;
    assign bus.out_valid = active & ~empty;
    assign bus.out_data  = bus.out_valid ? rdata : '0;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;
    assign op   = fifo_op_e'({pop, push});

    assign count       = cnt;
    assign almost_full = (cnt >= AF_CNT);

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else if (!hold) begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case (op)
                OP_PUSH: cnt <= cnt + 1'b1;
                OP_POP:  cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // A write attempt against a full buffer is a lost symbol upstream
            if (bus.in_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

    gf_sym_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_gf_symbol_fifo.sv
// Self-checking bench for gf_symbol_fifo: vector table, directed corner sequences
// and randomized traffic checked against a queue-based reference model.
module tb_gf_symbol_fifo;

    localparam int W  = 5;
    localparam int D  = 32;
    localparam int AF = 28;

    logic clock = 1'b0;
    logic reset;
    logic flush;
    logic hold;
    logic [5:0] count;
    logic almost_full;
    logic overflow;

    gf_symbol_fifo_if #(.WIDTH(W)) bus ();

    gf_symbol_fifo #(
        .WIDTH    (W),
        .DEPTH    (D),
        .AF_LEVEL (AF)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .hold        (hold),
        .bus         (bus.slave),
        .count       (count),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] q[$];
    logic         m_ovf;

    typedef struct {
        logic         rst, fl, hd, iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         e_ir, e_ov;
        logic [W-1:0] e_od;
        logic [5:0]   e_cnt;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic rst, input logic fl, input logic hd,
                         input logic iv, input logic [W-1:0] d, input logic ordy);
        logic act;
        int   s;
        reset         = rst;
        flush         = fl;
        hold          = hd;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        s   = q.size();
        act = !rst && !fl && !hd;
        check("model in_ready",    32'(bus.in_ready),  32'(act && s < D));
        check("model out_valid",   32'(bus.out_valid), 32'(act && s > 0));
        check("model out_data",    32'(bus.out_data),  (act && s > 0) ? 32'(q[0]) : 32'd0);
        check("model count",       32'(count),         32'(s));
        check("model almost_full", 32'(almost_full),   32'(s >= AF));
        check("model overflow",    32'(overflow),      32'(m_ovf));
    endtask

    // Advance one edge and move the reference model by the rules of the handshake
    task automatic tick();
        bit do_push, do_pop;
        @(posedge clock);
        if (reset || flush) begin
            q.delete();
            m_ovf = 1'b0;
        end else if (!hold) begin
            do_push = bus.in_valid && (q.size() < D);
            do_pop  = bus.out_ready && (q.size() > 0);
            if (bus.in_valid && q.size() == D) m_ovf = 1'b1;
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(bus.in_data);
        end
        #1;
    endtask

    task automatic cyc(input logic rst, input logic fl, input logic hd,
                       input logic iv, input logic [W-1:0] d, input logic ordy);
        apply(rst, fl, hd, iv, d, ordy);
        tick();
    endtask

    initial begin
        tbl[0]  = '{1, 0, 0, 1, 5'h05, 0,  0, 0, 5'h00, 6'd0};
        tbl[1]  = '{1, 0, 0, 1, 5'h05, 0,  0, 0, 5'h00, 6'd0};
        tbl[2]  = '{0, 0, 0, 1, 5'h07, 0,  1, 0, 5'h00, 6'd0};
        tbl[3]  = '{0, 0, 0, 1, 5'h09, 0,  1, 1, 5'h07, 6'd1};
        tbl[4]  = '{0, 0, 1, 1, 5'h02, 1,  0, 0, 5'h00, 6'd2};
        tbl[5]  = '{0, 0, 0, 0, 5'h00, 1,  1, 1, 5'h07, 6'd2};
        tbl[6]  = '{0, 0, 0, 1, 5'h04, 1,  1, 1, 5'h09, 6'd1};
        tbl[7]  = '{0, 1, 0, 1, 5'h06, 1,  0, 0, 5'h00, 6'd1};
        tbl[8]  = '{0, 0, 0, 1, 5'h1A, 0,  1, 0, 5'h00, 6'd0};
        tbl[9]  = '{0, 0, 0, 0, 5'h00, 0,  1, 1, 5'h1A, 6'd1};
        tbl[10] = '{0, 0, 0, 0, 5'h00, 1,  1, 1, 5'h1A, 6'd1};
        tbl[11] = '{0, 0, 0, 0, 5'h00, 0,  1, 0, 5'h00, 6'd0};

        // First edge under reset brings the DUT out of X before any comparison
        q.delete();
        m_ovf         = 1'b0;
        reset         = 1'b1;
        flush         = 1'b0;
        hold          = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 5'h03;
        bus.out_ready = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].rst, tbl[i].fl, tbl[i].hd, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            check($sformatf("vec%0d in_ready", i),  32'(bus.in_ready),  32'(tbl[i].e_ir));
            check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_ov));
            check($sformatf("vec%0d out_data", i),  32'(bus.out_data),  32'(tbl[i].e_od));
            check($sformatf("vec%0d count", i),     32'(count),         32'(tbl[i].e_cnt));
            tick();
        end

        // Fill 0..31 with no consumer
        for (int i = 0; i < D; i++) begin
            cyc(0, 0, 0, 1, W'(i), 0);
            check("fill almost_full", 32'(almost_full), 32'(i + 1 >= AF));
        end
        apply(0, 0, 0, 0, 5'h00, 0);
        check("full count",    32'(count),        32'd32);
        check("full in_ready", 32'(bus.in_ready), 32'd0);

        // Full with push and pop together: pop only, overflow latches
        apply(0, 0, 0, 1, 5'h15, 1);
        check("full+pp out_data", 32'(bus.out_data), 32'd0);
        tick();
        apply(0, 0, 0, 0, 5'h00, 0);
        check("full+pp count",    32'(count),    32'd31);
        check("full+pp overflow", 32'(overflow), 32'd1);

        for (int i = 1; i < D; i++) begin
            apply(0, 0, 0, 0, 5'h00, 1);
            check("drain order", 32'(bus.out_data), 32'(i));
            tick();
        end
        apply(0, 0, 0, 0, 5'h00, 0);
        check("drained count",     32'(count),         32'd0);
        check("drained out_valid", 32'(bus.out_valid), 32'd0);

        // Hold at count 10
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, W'(10 + i), 0);
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 1, 1, 5'h1F, 1);
            check("hold out_data", 32'(bus.out_data), 32'd0);
            check("hold count",    32'(count),        32'd10);
            tick();
        end
        apply(0, 0, 0, 0, 5'h00, 0);
        check("post-hold head",  32'(bus.out_data), 32'h0A);
        check("post-hold count", 32'(count),        32'd10);

        // Streaming at count 4 across several pointer wraps
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 5'h00, 1);
        for (int i = 0; i < 100; i++) cyc(0, 0, 0, 1, W'($urandom), 1);
        apply(0, 0, 0, 0, 5'h00, 0);
        check("stream count", 32'(count), 32'd4);

        // Flush at count 17 with traffic on both sides
        for (int i = 0; i < 13; i++) cyc(0, 0, 0, 1, W'($urandom), 0);
        apply(0, 1, 0, 1, 5'h11, 1);
        check("pre-flush count", 32'(count), 32'd17);
        tick();
        apply(0, 0, 0, 0, 5'h00, 0);
        check("flush count",     32'(count),         32'd0);
        check("flush out_valid", 32'(bus.out_valid), 32'd0);
        check("flush overflow",  32'(overflow),      32'd0);
        tick();
        cyc(0, 0, 0, 1, 5'h1A, 0);
        apply(0, 0, 0, 0, 5'h00, 0);
        check("post-flush data", 32'(bus.out_data), 32'h1A);
        tick();

        // Randomized traffic with phases biased toward full and toward empty
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 500; i++) begin
                logic r_rst, r_fl, r_hd, r_iv, r_or;
                r_rst = ($urandom_range(0, 299) == 0);
                r_fl  = ($urandom_range(0, 149) == 0);
                r_hd  = ($urandom_range(0, 9) == 0);
                r_iv  = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 85 : 30));
                r_or  = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 30 : 85));
                cyc(r_rst, r_fl, r_hd, r_iv, W'($urandom), r_or);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
